// File: rtl/vga_pll_reset_sequencer.sv
// vga_pll_reset_sequencer
// Power-up and lock supervision for the VGA PLL, clocked by the 50 MHz reference.
// The block pulses the PLL reset and then waits for lock. A lock wait that times out
// is retried a bounded number of times. Lock must stay stable before the downstream
// resets are released, and losing lock re-sequences the PLL.
//
// state       | meaning
// ------------+----------------------------------------------------------
// PLL_RESET   | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK   | pll_rst low, waiting for synced lock, bounded by timeout
// STABLE      | lock seen, must hold for STABLE_CYCLES consecutive cycles
// RUN         | downstream released (sys_rst low, ready high)
// FAULT       | retries exhausted; left only on rst or force_relock

module vga_pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] relock_count
);

    localparam int MAX_AB   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_TERM = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TW       = $clog2(MAX_TERM) + 1;
    localparam int RW       = $clog2(MAX_RETRIES) + 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cnt;
    logic [RW-1:0] retries;
    logic [RW-1:0] retries_nxt;
    logic          cnt_clr;
    logic          cnt_run;
    logic          relock_inc;
    logic          lk_m;
    logic          lk_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= locked;
            lk_s <= lk_m;
        end
    end

    // Next-state, retry bookkeeping and relock event decode.
    always_comb begin
        state_nxt   = state;
        retries_nxt = retries;
        relock_inc  = 1'b0;
        if (force_relock) begin
            state_nxt   = S_PLL_RESET;
            retries_nxt = '0;
        end else begin
            case (state)
                S_PLL_RESET: begin
                    if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retries_nxt = retries + RW'(1);
                        state_nxt   = (retries_nxt == RETRY_LIMIT) ? S_FAULT : S_PLL_RESET;
                    end
                end
                S_STABLE: begin
                    // A lock drop beats completion in the same cycle.
                    if (!lk_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt   = S_RUN;
                        retries_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state_nxt  = S_PLL_RESET;
                        relock_inc = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_PLL_RESET;
                end
            endcase
        end
    end

    // force_relock must also clear cnt when it re-enters PLL_RESET from PLL_RESET.
    always_comb begin
        cnt_clr = force_relock || (state_nxt != state);
        cnt_run = (state == S_PLL_RESET) || (state == S_WAIT_LOCK) || (state == S_STABLE);
    end

    // State, shared counter, retries and registered outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= S_PLL_RESET;
            cnt          <= '0;
            retries      <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
            relock_count <= '0;
        end else begin
            state   <= state_nxt;
            retries <= retries_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + TW'(1);
            end
            pll_rst <= (state_nxt == S_PLL_RESET);
            sys_rst <= (state_nxt != S_RUN);
            ready   <= (state_nxt == S_RUN);
            fault   <= (state_nxt == S_FAULT);
            if (relock_inc && (relock_count != {CNT_W{1'b1}})) begin
                relock_count <= relock_count + CNT_W'(1);
            end
        end
    end

endmodule
